// File: rtl/display_frame_sequencer_if.sv
// Handshake bundle between the frame sequencer, the display buffer updater
// and the LCD driver (window request, per-pixel update, pixel stream).
interface display_frame_sequencer_if #(
  parameter int X_W = 8,
  parameter int Y_W = 7
);
  logic           win_req;
  logic           win_ack;
  logic           update;
  logic [X_W-1:0] update_x;
  logic [Y_W-1:0] update_y;
  logic           done;
  logic [15:0]    done_color;
  logic           pix_valid;
  logic [15:0]    pix_data;
  logic           pix_ready;

  modport master (
    output win_req, update, update_x, update_y, pix_valid, pix_data,
    input  win_ack, done, done_color, pix_ready
  );

  modport slave (
    input  win_req, update, update_x, update_y, pix_valid, pix_data,
    output win_ack, done, done_color, pix_ready
  );
endinterface

// File: rtl/display_frame_sequencer.sv
// Walks every pixel of a frame in row-major order: update request to the
// buffer updater, wait for its colour, then stream it to the LCD driver.
//
// state  | meaning
// IDLE   | no frame in progress, waiting for frame_req or pending
// WIN    | win_req high until the LCD driver acks the window
// ISSUE  | one-cycle update pulse for the current pixel
// WAIT   | waiting for done, bounded by the timeout counter
// PUSH   | pix_valid high until pix_ready
// ADV    | step to the next pixel or finish
// FINISH | frame_done pulse
module display_frame_sequencer #(
  parameter int X_MAX        = 160,
  parameter int Y_MAX        = 80,
  parameter int X_W          = $clog2(X_MAX),
  parameter int Y_W          = $clog2(Y_MAX),
  parameter int DONE_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_req,
  output logic busy,
  output logic frame_done,
  output logic frame_overrun,
  output logic timeout_err,
  display_frame_sequencer_if.master bus
);

  localparam int T_W = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WIN, S_ISSUE, S_WAIT, S_PUSH, S_ADV, S_FINISH
  } state_t;

  state_t         state;
  logic           pending;
  logic [T_W-1:0] tmo_cnt;

  wire last_x = (bus.update_x == X_W'(X_MAX - 1));
  wire last_y = (bus.update_y == Y_W'(Y_MAX - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      pending       <= 1'b0;
      tmo_cnt       <= '0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      frame_overrun <= 1'b0;
      timeout_err   <= 1'b0;
      bus.win_req   <= 1'b0;
      bus.update    <= 1'b0;
      bus.update_x  <= '0;
      bus.update_y  <= '0;
      bus.pix_valid <= 1'b0;
      bus.pix_data  <= '0;
    end else begin
      frame_done    <= 1'b0;
      frame_overrun <= 1'b0;
      bus.update    <= 1'b0;

      // One request may queue behind a running frame; a second one is dropped.
      if (frame_req && state != S_IDLE) begin
        if (!pending) pending       <= 1'b1;
        else          frame_overrun <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (frame_req || pending) begin
            pending      <= 1'b0;
            timeout_err  <= 1'b0;
            bus.update_x <= '0;
            bus.update_y <= '0;
            busy         <= 1'b1;
            bus.win_req  <= 1'b1;
            state        <= S_WIN;
          end
        end
        S_WIN: begin
          if (bus.win_ack) begin
            bus.win_req <= 1'b0;
            bus.update  <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tmo_cnt <= T_W'(DONE_TIMEOUT - 1);
          state   <= S_WAIT;
        end
        S_WAIT: begin
          // done takes priority over an expiring timeout in the same cycle.
          if (bus.done) begin
            bus.pix_data  <= bus.done_color;
            bus.pix_valid <= 1'b1;
            state         <= S_PUSH;
          end else if (tmo_cnt == '0) begin
            bus.pix_data  <= '0;
            bus.pix_valid <= 1'b1;
            timeout_err   <= 1'b1;
            state         <= S_PUSH;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        S_PUSH: begin
          if (bus.pix_ready) begin
            bus.pix_valid <= 1'b0;
            state         <= S_ADV;
          end
        end
        S_ADV: begin
          if (last_x && last_y) begin
            frame_done <= 1'b1;
            state      <= S_FINISH;
          end else begin
            if (last_x) begin
              bus.update_x <= '0;
              bus.update_y <= bus.update_y + 1'b1;
            end else begin
              bus.update_x <= bus.update_x + 1'b1;
            end
            bus.update <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_FINISH: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_display_frame_sequencer.sv
// Directed plus randomized bench for display_frame_sequencer on a 4x2 screen,
// with an updater/LCD environment and a per-pixel expectation table.
module tb_display_frame_sequencer;
  localparam int XM = 4;
  localparam int YM = 2;
  localparam int NPIX = XM * YM;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_req = 1'b0;
  logic busy, frame_done, frame_overrun, timeout_err;

  display_frame_sequencer_if #(.X_W(2), .Y_W(1)) bus ();

  display_frame_sequencer #(.X_MAX(XM), .Y_MAX(YM), .DONE_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .frame_req(frame_req), .busy(busy),
    .frame_done(frame_done), .frame_overrun(frame_overrun),
    .timeout_err(timeout_err), .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Per-frame scenario: updater latency per pixel (0 = never answers), colour salt.
  int dly [NPIX];
  logic [7:0] salt = 8'h00;
  int ack_n = 1;
  int rmode = 0;

  int idx = 0, cyc = 0, frames = 0, overruns = 0, updates = 0;
  int cd = -1, upd_cyc = 0, wcnt = 0, ux = 0, uy = 0;
  bit in_flight = 0, win_ok = 0, prev_valid = 0, prev_ready = 0, prev_upd = 0, prev_fd = 0;
  logic [15:0] prev_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] colour(int x, int y);
    return {salt, 4'(x), 4'(y)};
  endfunction

  function automatic logic [15:0] exp_pix(int i);
    if (dly[i] == 0 || dly[i] > TO) return 16'h0000;
    return colour(i % XM, i / XM);
  endfunction

  function automatic int exp_gap(int i);
    if (dly[i] == 0 || dly[i] > TO) return TO + 1;
    return dly[i] + 1;
  endfunction

  // Environment: drive updater/LCD inputs first, then check DUT outputs.
  always @(negedge clk) begin
    if (!rst_n) begin
      bus.done = 1'b0; bus.done_color = '0; bus.win_ack = 1'b0; bus.pix_ready = 1'b0;
      idx = 0; cd = -1; wcnt = 0; in_flight = 0; win_ok = 0;
      prev_valid = 0; prev_ready = 0; prev_upd = 0; prev_fd = 0;
    end else begin
      bus.done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin bus.done = 1'b1; bus.done_color = colour(ux, uy); end
      end
      bus.win_ack = bus.win_req && (wcnt == ack_n - 1);
      case (rmode)
        0: bus.pix_ready = 1'b1;
        1: bus.pix_ready = (cyc % 3 == 0);
        default: bus.pix_ready = 1'($urandom_range(0, 1));
      endcase

      if (bus.win_req) begin
        if (bus.win_ack) win_ok = 1;
        wcnt++;
      end else if (wcnt > 0) begin
        check("win_req_len", wcnt, ack_n);
        wcnt = 0;
      end
      if (bus.update) begin
        check("upd_after_win", win_ok, 1);
        check("upd_one_cycle", prev_upd, 0);
        check("upd_outstanding", in_flight, 0);
        check("upd_x", bus.update_x, idx % XM);
        check("upd_y", bus.update_y, idx / XM);
        in_flight = 1; upd_cyc = cyc; updates++;
        ux = bus.update_x; uy = bus.update_y;
        cd = (dly[idx] > 0) ? dly[idx] : -1;
      end
      if (prev_valid && prev_ready) check("pix_valid_drop", bus.pix_valid, 0);
      if (bus.pix_valid) begin
        if (!prev_valid) check("pix_gap", cyc - upd_cyc, exp_gap(idx));
        else if (!prev_ready) check("pix_hold", bus.pix_data, prev_data);
        if (bus.pix_ready) begin
          check("pix_data", bus.pix_data, exp_pix(idx));
          in_flight = 0;
          idx++;
        end
      end
      if (prev_fd) check("busy_after_done", busy, 0);
      if (frame_done) begin
        check("done_pix_count", idx, NPIX);
        frames++; idx = 0; win_ok = 0;
      end
      if (frame_overrun) overruns++;
      prev_valid = bus.pix_valid; prev_ready = bus.pix_ready; prev_data = bus.pix_data;
      prev_upd = bus.update; prev_fd = frame_done;
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_req();
    frame_req = 1'b1; step(); frame_req = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames < target && n < budget) begin step(); n++; end
    check("frame_in_budget", frames >= target, 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin step(); n++; end
    check("idle_in_budget", busy, 0);
  endtask

  task automatic set_uniform(input int d);
    for (int i = 0; i < NPIX; i++) dly[i] = d;
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overrun", frame_overrun, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_win_req", bus.win_req, 0);
    check("rst_update", bus.update, 0);
    check("rst_pix_valid", bus.pix_valid, 0);
    check("rst_update_x", bus.update_x, 0);
    check("rst_update_y", bus.update_y, 0);
    check("rst_pix_data", bus.pix_data, 0);
  endtask

  task automatic run_frame(input bit exp_err);
    int f0 = frames;
    int u0 = updates;
    pulse_req();
    wait_frames(f0 + 1, 1500);
    wait_idle(20);
    check("frame_count", frames, f0 + 1);
    check("update_count", updates - u0, NPIX);
    check("timeout_err", timeout_err, exp_err);
  endtask

  initial begin
    int f0, o0, n;
    bit err;
    set_uniform(5);
    repeat (3) step();
    check_reset_outputs();
    rst_n = 1'b1;
    step();

    // Nominal frame, pix_ready always high.
    salt = 8'($urandom); set_uniform(5); ack_n = 1; rmode = 0;
    run_frame(1'b0);
    check("no_overrun", overruns, 0);

    // Slow window ack, pix_ready high one cycle in three.
    salt = 8'($urandom); ack_n = 10; rmode = 1;
    run_frame(1'b0);

    // Pixel (2,1) never answered.
    salt = 8'($urandom); ack_n = 1; rmode = 0;
    set_uniform(5); dly[2 + 1 * XM] = 0;
    run_frame(1'b1);

    // Error clears at frame start; done in the last WAIT cycle still wins.
    set_uniform(5); dly[1] = TO;
    f0 = frames;
    pulse_req();
    check("err_clear_on_start", timeout_err, 0);
    wait_frames(f0 + 1, 1500);
    wait_idle(20);
    check("tie_no_err", timeout_err, 0);

    // done arriving one cycle after the timeout is ignored.
    set_uniform(3); dly[3] = TO + 1;
    run_frame(1'b1);

    // Three requests in one frame: one queued, one dropped.
    set_uniform(5); o0 = overruns; f0 = frames;
    pulse_req();
    repeat (20) step();
    pulse_req();
    repeat (20) step();
    pulse_req();
    wait_frames(f0 + 2, 3000);
    wait_idle(20);
    check("overrun_pulses", overruns - o0, 1);
    check("queued_frame_ran", frames, f0 + 2);
    repeat (5) step();
    check("no_third_frame", busy, 0);

    // Request landing in the FINISH cycle is queued.
    o0 = overruns; f0 = frames;
    pulse_req();
    n = 0;
    while (!frame_done && n < 1500) begin step(); n++; end
    check("finish_seen", frame_done, 1);
    pulse_req();
    wait_frames(f0 + 2, 1500);
    wait_idle(20);
    check("finish_req_frames", frames, f0 + 2);
    check("finish_req_no_overrun", overruns, o0);

    // Reset during PUSH of pixel 3.
    f0 = frames;
    pulse_req();
    n = 0;
    while (!(bus.pix_valid && idx == 3) && n < 500) begin step(); n++; end
    check("push3_seen", bus.pix_valid && idx == 3, 1);
    rst_n = 1'b0;
    step();
    check_reset_outputs();
    rst_n = 1'b1;
    repeat (3) step();
    check("rst_no_frame_done", frames, f0);
    check("rst_no_restart", busy, 0);
    run_frame(1'b0);

    // Randomized frames.
    for (int k = 0; k < 4; k++) begin
      salt = 8'($urandom); ack_n = $urandom_range(1, 6); rmode = 2;
      for (int i = 0; i < NPIX; i++) dly[i] = $urandom_range(1, 9);
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 2))
          0: dly[$urandom_range(0, NPIX - 1)] = 0;
          1: dly[$urandom_range(0, NPIX - 1)] = TO;
          default: dly[$urandom_range(0, NPIX - 1)] = TO + 1;
        endcase
      end
      err = 1'b0;
      for (int i = 0; i < NPIX; i++) if (dly[i] == 0 || dly[i] > TO) err = 1'b1;
      run_frame(err);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
